// File: rtl/uart_frame_scheduler_pkg.sv
// Shared definitions for the UART frame scheduler slice.
//  frameState_t : byte type currently held in the output register
//  SYNC_NIBBLE  : upper nibble of every header byte
//  SRC_ADC/STAT : source identifiers (also the low bit of the header)
//  headerByte() : builds the header byte for a granted source
package uart_frame_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_SEQ      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_CHECKSUM = 3'd4
  } frameState_t;

  localparam logic [3:0] SYNC_NIBBLE = 4'hA;
  localparam logic       SRC_ADC     = 1'b0;
  localparam logic       SRC_STAT    = 1'b1;

  function automatic logic [7:0] headerByte(input logic src);
    return {SYNC_NIBBLE, 3'b000, src};
  endfunction

endpackage

// File: rtl/uart_frame_scheduler_if.sv
// Byte-stream bundle between the two sources, the scheduler and the UART
// transmitter.
//  master modport : the scheduler (consumes sources, drives transmitter)
//  slave modport  : the surrounding logic (sources, transmitter, control)
//  enable               new frames may start
//  adcData/Valid/Ready  source 0 handshake
//  statData/Valid/Ready source 1 handshake
//  txData/Valid/Ready   transmitter handshake
//  frameSeq             sequence number of the next frame
//  stallErr             sticky pad-inserted flag
//  busy                 a frame is in progress
interface uart_frame_scheduler_if;
  logic       enable;
  logic [7:0] adcData;
  logic       adcValid;
  logic       adcReady;
  logic [7:0] statData;
  logic       statValid;
  logic       statReady;
  logic [7:0] txData;
  logic       txValid;
  logic       txReady;
  logic [7:0] frameSeq;
  logic       stallErr;
  logic       busy;

  modport master (
    input  enable, adcData, adcValid, statData, statValid, txReady,
    output adcReady, statReady, txData, txValid, frameSeq, stallErr, busy
  );

  modport slave (
    output enable, adcData, adcValid, statData, statValid, txReady,
    input  adcReady, statReady, txData, txValid, frameSeq, stallErr, busy
  );
endinterface

// File: rtl/uart_frame_scheduler_arb.sv
// Two-way round-robin arbiter (purely combinational).
//  req[1:0]  : request per source (bit 0 = ADC, bit 1 = status)
//  lastGrant : source granted most recently
//  load      : a grant may be issued this cycle
//  grant     : selected source
//  valid     : grant is meaningful (load and at least one request)
module uart_rr_arb2
  import uart_frame_scheduler_pkg::*;
(
  input  logic [1:0] req,
  input  logic       lastGrant,
  input  logic       load,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = load & (|req);
    unique case (req)
      2'b01:   grant = SRC_ADC;
      2'b10:   grant = SRC_STAT;
      2'b11:   grant = ~lastGrant;  // tie goes to whoever did not win last
      default: grant = SRC_ADC;
    endcase
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one UART transmitter between the ADC stream (src 0) and the
// status stream (src 1). Each grant emits one frame:
//   header (A0|src), sequence, PAYLOAD_LEN payload bytes, checksum.
// The checksum makes the byte sum of the whole frame zero mod 256.
//  clk : system clock, rising edge
//  rst : asynchronous active-low reset
//  bus : uart_frame_scheduler_if master modport (sources, transmitter,
//        enable, frameSeq, stallErr, busy)
module uart_frame_scheduler
  import uart_frame_scheduler_pkg::*;
#(
  parameter int         PAYLOAD_LEN  = 8,
  parameter int         STALL_CYCLES = 1024,
  parameter logic [7:0] PAD_BYTE     = 8'h00
) (
  input logic                    clk,
  input logic                    rst,
  uart_frame_scheduler_if.master bus
);

  localparam int                 STALL_W    = $clog2(STALL_CYCLES + 1);
  localparam logic [7:0]         LAST_CNT   = 8'(PAYLOAD_LEN);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  frameState_t        stateReg, stateNext;
  logic [7:0]         txDataReg, txDataNext;
  logic               txValidReg, txValidNext;
  logic               grantReg, grantNext;
  logic               lastGrantReg, lastGrantNext;
  logic [7:0]         sumReg, sumNext;
  logic [7:0]         cntReg, cntNext;
  logic [STALL_W-1:0] stallCntReg, stallCntNext;
  logic [7:0]         frameSeqReg, frameSeqNext;
  logic               stallErrReg, stallErrNext;

  logic       slotFree;
  logic       txFire;
  logic       srcValid;
  logic [7:0] srcData;
  logic       srcTake;
  logic       arbLoad;
  logic       arbGrant;
  logic       arbValid;

  assign slotFree = ~txValidReg | bus.txReady;
  assign txFire   = txValidReg & bus.txReady;
  assign srcValid = (grantReg == SRC_STAT) ? bus.statValid : bus.adcValid;
  assign srcData  = (grantReg == SRC_STAT) ? bus.statData  : bus.adcData;
  // enable only matters while idle; a running frame always completes
  assign arbLoad  = (stateReg == ST_IDLE) & bus.enable & slotFree;

  uart_rr_arb2 arb (
    .req      ({bus.statValid, bus.adcValid}),
    .lastGrant(lastGrantReg),
    .load     (arbLoad),
    .grant    (arbGrant),
    .valid    (arbValid)
  );

  always_comb begin
    stateNext     = stateReg;
    txDataNext    = txDataReg;
    txValidNext   = txValidReg;
    grantNext     = grantReg;
    lastGrantNext = lastGrantReg;
    sumNext       = sumReg;
    cntNext       = cntReg;
    stallCntNext  = stallCntReg;
    frameSeqNext  = frameSeqReg;
    stallErrNext  = stallErrReg;
    srcTake       = 1'b0;

    unique case (stateReg)
      ST_IDLE: begin
        if (arbValid) begin
          grantNext     = arbGrant;
          lastGrantNext = arbGrant;
          txDataNext    = headerByte(arbGrant);
          txValidNext   = 1'b1;
          sumNext       = headerByte(arbGrant);
          cntNext       = 8'd0;
          stallCntNext  = '0;
          stateNext     = ST_HEADER;
        end
      end

      ST_HEADER: begin
        if (txFire) begin
          txDataNext = frameSeqReg;
          sumNext    = sumReg + frameSeqReg;
          stateNext  = ST_SEQ;
        end
      end

      ST_SEQ, ST_PAYLOAD: begin
        if (slotFree) begin
          if (cntReg == LAST_CNT) begin
            // every payload byte is loaded and the last one is leaving now
            txDataNext  = ~sumReg + 8'd1;
            txValidNext = 1'b1;
            stateNext   = ST_CHECKSUM;
          end else if (srcValid) begin
            srcTake      = 1'b1;
            txDataNext   = srcData;
            txValidNext  = 1'b1;
            sumNext      = sumReg + srcData;
            cntNext      = cntReg + 8'd1;
            stallCntNext = '0;
            stateNext    = ST_PAYLOAD;
          end else if (stallCntReg == STALL_LAST) begin
            // source has been silent long enough: substitute a pad byte
            txDataNext   = PAD_BYTE;
            txValidNext  = 1'b1;
            sumNext      = sumReg + PAD_BYTE;
            cntNext      = cntReg + 8'd1;
            stallCntNext = '0;
            stallErrNext = 1'b1;
            stateNext    = ST_PAYLOAD;
          end else begin
            // nothing to send: empty the output register and keep waiting
            txValidNext  = 1'b0;
            stallCntNext = stallCntReg + STALL_W'(1);
          end
        end
      end

      ST_CHECKSUM: begin
        if (txFire) begin
          txValidNext  = 1'b0;
          frameSeqNext = frameSeqReg + 8'd1;
          stateNext    = ST_IDLE;
        end
      end

      default: begin
        stateNext   = ST_IDLE;
        txValidNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg     <= ST_IDLE;
      txDataReg    <= 8'h00;
      txValidReg   <= 1'b0;
      grantReg     <= SRC_ADC;
      lastGrantReg <= SRC_STAT;  // so the ADC wins the first tie
      sumReg       <= 8'h00;
      cntReg       <= 8'd0;
      stallCntReg  <= '0;
      frameSeqReg  <= 8'h00;
      stallErrReg  <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      txDataReg    <= txDataNext;
      txValidReg   <= txValidNext;
      grantReg     <= grantNext;
      lastGrantReg <= lastGrantNext;
      sumReg       <= sumNext;
      cntReg       <= cntNext;
      stallCntReg  <= stallCntNext;
      frameSeqReg  <= frameSeqNext;
      stallErrReg  <= stallErrNext;
    end
  end

  // ready is combinational from txReady so a byte moves in the same cycle
  assign bus.adcReady  = srcTake & (grantReg == SRC_ADC);
  assign bus.statReady = srcTake & (grantReg == SRC_STAT);
  assign bus.txData    = txDataReg;
  assign bus.txValid   = txValidReg;
  assign bus.frameSeq  = frameSeqReg;
  assign bus.stallErr  = stallErrReg;
  assign bus.busy      = (stateReg != ST_IDLE);

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Self-checking bench for uart_frame_scheduler.
// A byte-level model predicts every output each cycle; directed tests pin
// the model with hand-computed frame contents.
module tb_uart_frame_scheduler;

  localparam int         LEN   = 8;
  localparam int         STALL = 16;
  localparam logic [7:0] PAD   = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_frame_scheduler_if bus ();

  uart_frame_scheduler #(
    .PAYLOAD_LEN (LEN),
    .STALL_CYCLES(STALL),
    .PAD_BYTE    (PAD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- source queues ----------------
  logic [7:0] adcQ[$];
  logic [7:0] statQ[$];
  int adcTakes = 0, statTakes = 0, adcPopped = 0, statPopped = 0;

  task automatic drive();
    bus.adcValid  = (adcQ.size() > 0);
    bus.adcData   = (adcQ.size() > 0) ? adcQ[0] : 8'h00;
    bus.statValid = (statQ.size() > 0);
    bus.statData  = (statQ.size() > 0) ? statQ[0] : 8'h00;
  endtask

  // ---------------- model ----------------
  // mPhase: -1 idle, 0 header held, 1 seq held, 2 payload, 3 checksum held
  logic       mValid, mSrc, mLast, mErr;
  logic [7:0] mData, mSeq, mSum;
  int         mPhase, mLoaded, mStall;
  logic [7:0] wireLog[$];  // every byte the transmitter accepted
  int         gapCnt = 0;    // busy cycles with nothing offered
  int         readyCnt = 0;  // cycles with any source ready

  task automatic modelReset();
    mValid = 1'b0; mSrc = 1'b0; mLast = 1'b1; mErr = 1'b0;
    mData = 8'h00; mSeq = 8'h00; mSum = 8'h00;
    mPhase = -1; mLoaded = 0; mStall = 0;
  endtask

  task automatic compareCycle();
    logic slotFree, srcV, take;
    logic [7:0] srcD;
    if (!rst) begin
      check("rst_txValid", bus.txValid, 0);
      check("rst_txData", bus.txData, 0);
      check("rst_frameSeq", bus.frameSeq, 0);
      check("rst_stallErr", bus.stallErr, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_ready", bus.adcReady | bus.statReady, 0);
      modelReset();
      return;
    end
    slotFree = !mValid || bus.txReady;
    srcV = mSrc ? bus.statValid : bus.adcValid;
    srcD = mSrc ? bus.statData : bus.adcData;
    take = (mPhase == 1 || mPhase == 2) && slotFree && (mLoaded < LEN) && srcV;

    check("txValid", bus.txValid, mValid);
    if (mValid) check("txData", bus.txData, mData);
    check("adcReady", bus.adcReady, take && !mSrc);
    check("statReady", bus.statReady, take && mSrc);
    check("readyExcl", bus.adcReady & bus.statReady, 0);
    check("frameSeq", bus.frameSeq, mSeq);
    check("stallErr", bus.stallErr, mErr);
    check("busy", bus.busy, mPhase >= 0);

    if (bus.txValid && bus.txReady) wireLog.push_back(bus.txData);
    if (bus.adcReady && bus.adcValid) adcTakes++;
    if (bus.statReady && bus.statValid) statTakes++;
    if (!bus.txValid && bus.busy) gapCnt++;
    if (bus.adcReady || bus.statReady) readyCnt++;

    if (mPhase < 0) begin
      if (bus.enable && (bus.adcValid || bus.statValid)) begin
        mSrc = (bus.adcValid && bus.statValid) ? !mLast : bus.statValid;
        mLast = mSrc;
        mData = 8'hA0 + {7'd0, mSrc};
        mValid = 1'b1; mSum = mData; mLoaded = 0; mStall = 0; mPhase = 0;
      end
    end else if (mPhase == 0) begin
      if (mValid && bus.txReady) begin
        mData = mSeq; mSum = mSum + mSeq; mPhase = 1;
      end
    end else if (mPhase == 3) begin
      if (mValid && bus.txReady) begin
        mValid = 1'b0; mSeq = mSeq + 8'd1; mPhase = -1;
      end
    end else if (slotFree) begin
      if (mLoaded == LEN) begin
        mData = 8'h00 - mSum; mValid = 1'b1; mPhase = 3;
      end else if (srcV) begin
        mData = srcD; mSum = mSum + srcD; mLoaded++; mStall = 0;
        mValid = 1'b1; mPhase = 2;
      end else begin
        mStall++;
        if (mStall == STALL) begin
          mData = PAD; mSum = mSum + PAD; mLoaded++; mStall = 0;
          mErr = 1'b1; mValid = 1'b1; mPhase = 2;
        end else begin
          mValid = 1'b0;
        end
      end
    end
  endtask

  // one clock: compare at the falling edge, update stimulus just after rising
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      compareCycle();
      @(posedge clk);
      #1;
      while (adcPopped < adcTakes) begin
        if (adcQ.size() > 0) adcQ.delete(0);
        adcPopped++;
      end
      while (statPopped < statTakes) begin
        if (statQ.size() > 0) statQ.delete(0);
        statPopped++;
      end
      drive();
    end
  endtask

  task automatic waitLog(input int n, input int budget, input string name);
    int k = 0;
    while (wireLog.size() < n && k < budget) begin
      cyc(1);
      k++;
    end
    if (wireLog.size() < n) begin
      checks++;
      $display("FAIL %s timeout: got %0d bytes, expected %0d", name, wireLog.size(), n);
    end
  endtask

  function automatic logic [7:0] logAt(input int i);
    return (i < wireLog.size()) ? wireLog[i] : 8'hXX;
  endfunction

  function automatic logic [7:0] frameSum(input int from);
    logic [7:0] s = 8'h00;
    for (int i = 0; i < LEN + 3; i++) s = s + logAt(from + i);
    return s;
  endfunction

  // A0 + 00 + (01..08 = 0x24) = 0xC4, so the checksum is 0x3C
  logic [7:0] exp1 [11] = '{8'hA0, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08, 8'h3C};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, gap0, rdy0;
    modelReset();
    bus.enable = 1'b0;
    bus.txReady = 1'b0;
    drive();
    cyc(3);
    rst = 1'b1;
    cyc(2);

    // ---- 1: single ADC frame ----
    base = wireLog.size();
    bus.enable = 1'b1;
    bus.txReady = 1'b1;
    for (int i = 0; i < 8; i++) adcQ.push_back(8'(i + 1));
    drive();
    waitLog(base + 11, 100, "t1");
    for (int i = 0; i < 11; i++) check($sformatf("t1_byte%0d", i), logAt(base + i), exp1[i]);
    cyc(2);
    check("t1_frameSeq", bus.frameSeq, 1);

    // ---- 2: both sources pending -> status, ADC, status ----
    base = wireLog.size();
    for (int i = 0; i < 16; i++) statQ.push_back(8'(8'h80 + i));
    for (int i = 0; i < 8; i++) adcQ.push_back(8'(8'h10 + i));
    drive();
    waitLog(base + 33, 200, "t2");
    check("t2_hdr0", logAt(base), 8'hA1);
    check("t2_hdr1", logAt(base + 11), 8'hA0);
    check("t2_hdr2", logAt(base + 22), 8'hA1);
    check("t2_seq0", logAt(base + 1), 8'h01);
    check("t2_seq1", logAt(base + 12), 8'h02);
    check("t2_seq2", logAt(base + 23), 8'h03);
    // A0 + 02 + (10..17 = 0x9C) = 0x3E -> 0xC2
    check("t2_csum1", logAt(base + 21), 8'hC2);
    cyc(2);

    // ---- 3: transmitter stalls 50 cycles mid-payload ----
    base = wireLog.size();
    for (int i = 0; i < 8; i++) adcQ.push_back(8'(8'h30 + i));
    drive();
    waitLog(base + 4, 50, "t3a");
    bus.txReady = 1'b0;
    rdy0 = readyCnt;
    for (int i = 0; i < 50; i++) begin
      cyc(1);
      check("t3_holdData", bus.txData, 8'h32);
      check("t3_holdValid", bus.txValid, 1);
    end
    check("t3_noReady", readyCnt - rdy0, 0);
    check("t3_noXfer", wireLog.size(), base + 4);
    bus.txReady = 1'b1;
    waitLog(base + 11, 100, "t3b");
    check("t3_seq", logAt(base + 1), 8'h04);
    for (int i = 0; i < 8; i++) check($sformatf("t3_pay%0d", i), logAt(base + 2 + i), 8'h30 + i);
    // A0 + 04 + (30..37 = 0x9C) = 0x40 -> 0xC0
    check("t3_csum", logAt(base + 10), 8'hC0);
    cyc(2);

    // ---- 4: source goes quiet after 3 bytes -> pad after 16 idle cycles ----
    base = wireLog.size();
    gap0 = gapCnt;
    check("t4_errBefore", bus.stallErr, 0);
    for (int i = 0; i < 3; i++) adcQ.push_back(8'(8'h41 + i));
    drive();
    begin
      int k = 0;
      while (!bus.stallErr && k < 200) begin cyc(1); k++; end
      if (!bus.stallErr) begin
        checks++;
        $display("FAIL t4_stall timeout: stallErr got 0, expected 1");
      end
    end
    for (int i = 0; i < 4; i++) adcQ.push_back(8'(8'h44 + i));
    drive();
    waitLog(base + 11, 100, "t4");
    check("t4_pad", logAt(base + 5), PAD);
    check("t4_pay6", logAt(base + 6), 8'h44);
    // the cycle the third byte leaves is idle cycle 1; the pad is loaded on
    // idle cycle 16, so txValid is low for 15 cycles in between
    check("t4_gap", gapCnt - gap0, 15);
    // A0+05+C6+00+116 = 0x281 -> 0x7F
    check("t4_csum", logAt(base + 10), 8'h7F);
    check("t4_sumZero", frameSum(base), 0);
    cyc(3);
    check("t4_errSticky", bus.stallErr, 1);

    // ---- 5: sequence wrap, then enable dropped mid-frame ----
    base = wireLog.size();
    for (int i = 0; i < 252 * 8 + 8; i++) adcQ.push_back(8'(i));
    drive();
    waitLog(base + 251 * 11 + 3, 4000, "t5a");
    bus.enable = 1'b0;
    waitLog(base + 252 * 11, 100, "t5b");
    check("t5_seqFF", logAt(base + 249 * 11 + 1), 8'hFF);
    check("t5_seq00", logAt(base + 250 * 11 + 1), 8'h00);
    check("t5_seq01", logAt(base + 251 * 11 + 1), 8'h01);
    check("t5_sumZero", frameSum(base + 251 * 11), 0);
    cyc(10);
    check("t5_idleBusy", bus.busy, 0);
    check("t5_idleValid", bus.txValid, 0);
    check("t5_noNewFrame", wireLog.size(), base + 252 * 11);
    check("t5_frameSeq", bus.frameSeq, 2);

    // ---- 6: reset in the middle of a payload ----
    base = wireLog.size();
    bus.enable = 1'b1;
    waitLog(base + 5, 50, "t6a");
    #2;
    rst = 1'b0;
    #1;
    check("t6_rstValid", bus.txValid, 0);
    check("t6_rstSeq", bus.frameSeq, 0);
    check("t6_rstBusy", bus.busy, 0);
    cyc(2);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) adcQ.push_back(8'(8'h60 + i));
    drive();
    base = wireLog.size();
    waitLog(base + 2, 50, "t6b");
    bus.enable = 1'b0;
    check("t6_hdr", logAt(base), 8'hA0);
    check("t6_seq", logAt(base + 1), 8'h00);
    waitLog(base + 11, 100, "t6c");
    check("t6_sumZero", frameSum(base), 0);
    cyc(3);
    check("t6_frameSeq", bus.frameSeq, 1);
    check("t6_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
